tag_freelist_2w: RTL and testbench

//  Dual-issue, dual-retire tag free list for the rename/dispatch stage; successor to the single-port tag FIFO.

---
 rtl/tag_freelist_2w.sv | 79 +++++++
 tb/tb_tag_freelist_2w.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tag_freelist_2w.sv
// tag_freelist_2w: dual-issue/dual-retire tag free list with occupancy and almost-empty flags.
// Define TAGFL_ERR_EN to enable the sticky Err_Overflow/Err_Underflow flags; otherwise they are tied low.
module tag_freelist_2w #(
    parameter int TAG_W  = 5,
    parameter int AE_THR = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       Rd_en,
    output logic [TAG_W-1:0] Tag_Out0,
    output logic [TAG_W-1:0] Tag_Out1,
    output logic [1:0]       Tag_Valid,
    input  logic [TAG_W-1:0] RB_Tag0,
    input  logic             RB_Tag_Valid0,
    input  logic [TAG_W-1:0] RB_Tag1,
    input  logic             RB_Tag_Valid1,
    output logic [TAG_W:0]   Free_Count,
    output logic             tagFifo_full,
    output logic             tagFifo_empty,
    output logic             tagFifo_aempty,
    output logic             Err_Overflow,
    output logic             Err_Underflow
);
    localparam int NUM_TAGS = 1 << TAG_W;
    localparam logic [TAG_W:0] NT = (TAG_W+1)'(NUM_TAGS);
    localparam logic [TAG_W:0] AE = (TAG_W+1)'(AE_THR);

    logic [TAG_W-1:0] mem [NUM_TAGS];
    logic [TAG_W:0]   rptr, wptr, space;
    logic [TAG_W-1:0] ra, wa, wd0;
    logic             p0, p1, w0, w1;

    assign Free_Count     = wptr - rptr;
    assign space          = NT - Free_Count;
    assign ra             = rptr[TAG_W-1:0];
    assign wa             = wptr[TAG_W-1:0];
    assign Tag_Out0       = mem[ra];
    assign Tag_Out1       = mem[ra + TAG_W'(1)];
    assign Tag_Valid      = {|Free_Count[TAG_W:1], |Free_Count};
    assign tagFifo_full   = Free_Count == NT;
    assign tagFifo_empty  = Free_Count == '0;
    assign tagFifo_aempty = Free_Count < AE;
    assign p0             = Rd_en[0] & Tag_Valid[0];
    assign p1             = p0 & Rd_en[1] & Tag_Valid[1];
    // Retires compact in port order; space is judged on pre-edge occupancy only.
    assign w0             = (RB_Tag_Valid0 | RB_Tag_Valid1) & |space;
    assign w1             = RB_Tag_Valid0 & RB_Tag_Valid1 & |space[TAG_W:1];
    assign wd0            = RB_Tag_Valid0 ? RB_Tag0 : RB_Tag1;

    always_ff @(posedge clock) begin
        if (reset) begin
            rptr <= '0;
            wptr <= NT;
            for (int i = 0; i < NUM_TAGS; i++) mem[i] <= TAG_W'(i);
        end else begin
            rptr <= rptr + (TAG_W+1)'(p0) + (TAG_W+1)'(p1);
            wptr <= wptr + (TAG_W+1)'(w0) + (TAG_W+1)'(w1);
            if (w0) mem[wa] <= wd0;
            if (w1) mem[wa + TAG_W'(1)] <= RB_Tag1;
        end
    end

`ifdef TAGFL_ERR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            Err_Overflow  <= 1'b0;
            Err_Underflow <= 1'b0;
        end else begin
            Err_Overflow  <= Err_Overflow | ((RB_Tag_Valid0 | RB_Tag_Valid1) & ~w0)
                             | (RB_Tag_Valid0 & RB_Tag_Valid1 & ~w1);
            Err_Underflow <= Err_Underflow | (Rd_en[0] & ~Tag_Valid[0])
                             | (&Rd_en & ~Tag_Valid[1]);
        end
    end
`else
    assign Err_Overflow  = 1'b0;
    assign Err_Underflow = 1'b0;
`endif
endmodule

// File: tb/tb_tag_freelist_2w.sv
// tb_tag_freelist_2w: directed and random stimulus checked every cycle against a queue model of the free list.
module tb_tag_freelist_2w;
    logic       clock = 0, reset = 1;
    logic [1:0] Rd_en = 0;
    logic [4:0] Tag_Out0, Tag_Out1, RB_Tag0 = 0, RB_Tag1 = 0;
    logic [1:0] Tag_Valid;
    logic       RB_Tag_Valid0 = 0, RB_Tag_Valid1 = 0;
    logic [5:0] Free_Count;
    logic       tagFifo_full, tagFifo_empty, tagFifo_aempty, Err_Overflow, Err_Underflow;

`ifdef TAGFL_ERR_EN
    localparam bit ERR = 1;
`else
    localparam bit ERR = 0;
`endif

    int tests = 0, fails = 0;
    int q[$];
    int acc[$];
    bit m_ovf = 0, m_unf = 0, chk_en = 0;

    tag_freelist_2w dut (
        .clock(clock), .reset(reset), .Rd_en(Rd_en),
        .Tag_Out0(Tag_Out0), .Tag_Out1(Tag_Out1), .Tag_Valid(Tag_Valid),
        .RB_Tag0(RB_Tag0), .RB_Tag_Valid0(RB_Tag_Valid0),
        .RB_Tag1(RB_Tag1), .RB_Tag_Valid1(RB_Tag_Valid1),
        .Free_Count(Free_Count), .tagFifo_full(tagFifo_full),
        .tagFifo_empty(tagFifo_empty), .tagFifo_aempty(tagFifo_aempty),
        .Err_Overflow(Err_Overflow), .Err_Underflow(Err_Underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of free tags; pops come from the front, accepted retires join the back.
    always @(posedge clock) begin
        int fc, np;
        if (reset) begin
            q.delete();
            for (int i = 0; i < 32; i++) q.push_back(i);
            m_ovf  = 0;
            m_unf  = 0;
            chk_en = 1;
        end else begin
            fc = q.size();
            np = (Rd_en[0] && fc >= 1) ? ((Rd_en[1] && fc >= 2) ? 2 : 1) : 0;
            if ((Rd_en[0] && fc < 1) || (Rd_en == 2'b11 && fc < 2)) m_unf = 1;
            acc.delete();
            if (RB_Tag_Valid0) acc.push_back(int'(RB_Tag0));
            if (RB_Tag_Valid1) acc.push_back(int'(RB_Tag1));
            while (acc.size() > 32 - fc) begin
                m_ovf = 1;
                void'(acc.pop_back());
            end
            repeat (np) void'(q.pop_front());
            foreach (acc[i]) q.push_back(acc[i]);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("free_count", int'(Free_Count), q.size());
            chk("tag_valid", int'(Tag_Valid), (q.size() >= 2) ? 3 : (q.size() >= 1) ? 1 : 0);
            chk("full", int'(tagFifo_full), int'(q.size() == 32));
            chk("empty", int'(tagFifo_empty), int'(q.size() == 0));
            chk("aempty", int'(tagFifo_aempty), int'(q.size() < 2));
            chk("err_ovf", int'(Err_Overflow), ERR ? int'(m_ovf) : 0);
            chk("err_unf", int'(Err_Underflow), ERR ? int'(m_unf) : 0);
            if (q.size() >= 1) chk("tag_out0", int'(Tag_Out0), q[0]);
            if (q.size() >= 2) chk("tag_out1", int'(Tag_Out1), q[1]);
        end
    end

    task automatic cyc(input logic [1:0] rd, input logic v0, input int t0, input logic v1, input int t1);
        Rd_en = rd;
        RB_Tag_Valid0 = v0;
        RB_Tag0 = 5'(t0);
        RB_Tag_Valid1 = v1;
        RB_Tag1 = 5'(t1);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_fc"}, int'(Free_Count), 32);
        chk({tag, "_full"}, int'(tagFifo_full), 1);
        chk({tag, "_empty"}, int'(tagFifo_empty), 0);
        chk({tag, "_aempty"}, int'(tagFifo_aempty), 0);
        chk({tag, "_out0"}, int'(Tag_Out0), 0);
        chk({tag, "_out1"}, int'(Tag_Out1), 1);
        chk({tag, "_valid"}, int'(Tag_Valid), 3);
        chk({tag, "_errs"}, int'({Err_Overflow, Err_Underflow}), 0);
    endtask

    initial begin
        reset = 1;
        cyc(0, 0, 0, 0, 0);
        cyc(3, 1, 4, 1, 5);
        reset = 0;
        chk_reset_state("t1");
        for (int i = 0; i < 16; i++) begin
            chk("t2_head0", int'(Tag_Out0), 2 * i);
            chk("t2_head1", int'(Tag_Out1), 2 * i + 1);
            cyc(3, 0, 0, 0, 0);
        end
        chk("t2_fc", int'(Free_Count), 0);
        chk("t2_flags", int'({tagFifo_empty, tagFifo_aempty, tagFifo_full}), 3'b110);
        chk("t2_valid", int'(Tag_Valid), 0);
        cyc(0, 0, 0, 1, 7);
        chk("t3_out0", int'(Tag_Out0), 7);
        chk("t3_valid", int'(Tag_Valid), 1);
        chk("t3_fc", int'(Free_Count), 1);
        cyc(3, 0, 0, 0, 0);
        chk("t3_fc_after", int'(Free_Count), 0);
        chk("t3_unf", int'(Err_Underflow), ERR ? 1 : 0);
        for (int i = 0; i < 15; i++) cyc(0, 1, 2 * i, 1, 2 * i + 1);
        cyc(0, 1, 30, 0, 0);
        chk("t4_fc31", int'(Free_Count), 31);
        chk("t4_ovf_pre", int'(Err_Overflow), 0);
        cyc(0, 1, 3, 1, 9);
        chk("t4_fc", int'(Free_Count), 32);
        chk("t4_full", int'(tagFifo_full), 1);
        chk("t4_ovf", int'(Err_Overflow), ERR ? 1 : 0);
        repeat (13) cyc(3, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t5_fc", int'(Free_Count), 5);
        chk("t5_head0", int'(Tag_Out0), 27);
        chk("t5_head1", int'(Tag_Out1), 28);
        cyc(3, 1, 20, 1, 21);
        chk("t5_fc_same", int'(Free_Count), 5);
        chk("t5_next0", int'(Tag_Out0), 29);
        cyc(3, 0, 0, 0, 0);
        chk("t5_dropped_tag_absent", int'(Tag_Out0), 3);
        cyc(1, 0, 0, 0, 0);
        chk("t5_tail0", int'(Tag_Out0), 20);
        chk("t5_tail1", int'(Tag_Out1), 21);
        chk("t5_fc2", int'(Free_Count), 2);
        for (int i = 0; i < 200; i++)
            cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
        reset = 1;
        cyc(3, 1, 17, 1, 18);
        reset = 0;
        chk_reset_state("t6");
        for (int i = 0; i < 20; i++)
            cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
